// File: rtl/led_arbiter.sv
// Fixed-priority owner selection for the shared 6-bit status LED bank.
// A minimum hold time blocks preemption; blinking is gated per requester.
module led_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int HOLD_CYCLES  = 5_000_000,
    parameter int BLINK_CYCLES = 2_500_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [6*NUM_REQ-1:0]   pattern,
    input  logic [NUM_REQ-1:0]     blink,
    output logic [NUM_REQ-1:0]     grant,
    output logic [5:0]             led,
    output logic                   busy
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state;
    logic [IDX_W-1:0]     owner;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 phase;

    logic [5:0]           pat [NUM_REQ];
    logic [NUM_REQ-1:0]   others;
    logic [NUM_REQ-1:0]   higher;
    logic                 own_req;
    logic                 own_blink;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (v[i]) lowest_idx = IDX_W'(i);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (IDX_W'(i) == idx) onehot[i] = 1'b1;
    endfunction

    // Bits strictly above the owner in priority, i.e. indices below it.
    function automatic logic [NUM_REQ-1:0] above_mask(input logic [IDX_W-1:0] k);
        above_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            above_mask[i] = (IDX_W'(i) < k);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            pat[i] = pattern[6*i +: 6];
        own_req   = req[owner];
        own_blink = blink[owner];
        others    = req & ~onehot(owner);
        higher    = req & above_mask(owner);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            grant     <= '0;
            led       <= '0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            // led tracks the registered owner/phase, one cycle behind grant.
            led <= (state == OWN && phase) ? pat[owner] : 6'b000000;
            case (state)
                IDLE: begin
                    hold_cnt  <= '0;
                    blink_cnt <= '0;
                    phase     <= 1'b1;
                    if (|req) begin
                        state <= OWN;
                        owner <= lowest_idx(req);
                        grant <= onehot(lowest_idx(req));
                        busy  <= 1'b1;
                    end
                end
                OWN: begin
                    if (!own_req) begin
                        hold_cnt  <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b1;
                        if (|others) begin
                            owner <= lowest_idx(others);
                            grant <= onehot(lowest_idx(others));
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (hold_cnt == HOLD_MAX && |higher) begin
                        owner     <= lowest_idx(higher);
                        grant     <= onehot(lowest_idx(higher));
                        hold_cnt  <= '0;
                        blink_cnt <= '0;
                        phase     <= 1'b1;
                    end else begin
                        if (hold_cnt != HOLD_MAX)
                            hold_cnt <= hold_cnt + 1'b1;
                        if (!own_blink) begin
                            blink_cnt <= '0;
                            phase     <= 1'b1;
                        end else if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            phase     <= ~phase;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Table-driven bench for led_arbiter with a queue scoreboard of expected outputs.
module tb_led_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = '0;
    logic [17:0] pattern = '0;
    logic [2:0]  blink = '0;
    logic [2:0]  grant;
    logic [5:0]  led;
    logic        busy;

    led_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4), .BLINK_CYCLES(3)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .pattern(pattern),
        .blink(blink), .grant(grant), .led(led), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  blink;
        logic [17:0] pat;
        logic [2:0]  g;
        logic [5:0]  l;
        logic        b;
    } vec_t;

    typedef struct {
        logic [2:0] g;
        logic [5:0] l;
        logic       b;
        int         tag;
    } exp_t;

    localparam logic [5:0] P0 = 6'b101010;
    localparam logic [5:0] P1 = 6'b111111;
    localparam logic [5:0] P2 = 6'b011111;
    localparam logic [17:0] DEF = {P2, P1, P0};
    localparam logic [17:0] ALT = {6'b000000, 6'b000111, 6'b010101};

    vec_t seg_a[$];
    vec_t seg_b[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int tag, input logic [5:0] got, input logic [5:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %b expected %b", name, tag, got, want);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: empty when output sampled");
        end else begin
            e = sb.pop_front();
            check("grant", e.tag, {3'b000, grant}, {3'b000, e.g});
            check("led",   e.tag, led, e.l);
            check("busy",  e.tag, {5'b00000, busy}, {5'b00000, e.b});
        end
    endtask

    task automatic expect_now(input int tag, input logic [2:0] g, input logic [5:0] l, input logic b);
        sb.push_back('{g: g, l: l, b: b, tag: tag});
        compare_head();
    endtask

    task automatic add(inout vec_t q[$], input logic [2:0] r, input logic [2:0] bl,
                       input logic [17:0] p, input logic [2:0] g, input logic [5:0] l, input logic b);
        q.push_back('{req: r, blink: bl, pat: p, g: g, l: l, b: b});
    endtask

    task automatic run_seg(input vec_t q[$], input int base);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            req     = q[i].req;
            blink   = q[i].blink;
            pattern = q[i].pat;
            sb.push_back('{g: q[i].g, l: q[i].l, b: q[i].b, tag: base + i});
            @(posedge clk);
            #1;
            compare_head();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Single request, blocked then allowed preemption, release with waiters,
        // lower priority never preempts, blink on/off and blink gating.
        add(seg_a, 3'b100, 3'b000, DEF, 3'b100, 6'b000000, 1'b1);
        add(seg_a, 3'b101, 3'b000, DEF, 3'b100, P2, 1'b1);
        add(seg_a, 3'b101, 3'b000, DEF, 3'b100, P2, 1'b1);
        add(seg_a, 3'b101, 3'b000, DEF, 3'b100, P2, 1'b1);
        add(seg_a, 3'b101, 3'b000, DEF, 3'b100, P2, 1'b1);
        add(seg_a, 3'b101, 3'b000, DEF, 3'b001, P2, 1'b1);
        add(seg_a, 3'b001, 3'b000, DEF, 3'b001, P0, 1'b1);
        add(seg_a, 3'b110, 3'b000, DEF, 3'b010, P0, 1'b1);
        for (int i = 0; i < 5; i++)
            add(seg_a, 3'b110, 3'b000, DEF, 3'b010, P1, 1'b1);
        for (int i = 0; i < 7; i++)
            add(seg_a, 3'b010, 3'b010, DEF, 3'b010, (i >= 3 && i <= 5) ? 6'b000000 : P1, 1'b1);
        for (int i = 0; i < 4; i++)
            add(seg_a, 3'b010, 3'b101, DEF, 3'b010, P1, 1'b1);
        for (int i = 0; i < 4; i++)
            add(seg_a, 3'b010, 3'b010, DEF, 3'b010, (i == 3) ? 6'b000000 : P1, 1'b1);

        // After a mid-ownership reset: re-arbitration, owner pattern change,
        // release with no waiters, then priority from IDLE.
        add(seg_b, 3'b010, 3'b010, DEF, 3'b010, 6'b000000, 1'b1);
        add(seg_b, 3'b010, 3'b010, ALT, 3'b010, 6'b000111, 1'b1);
        add(seg_b, 3'b000, 3'b010, ALT, 3'b000, 6'b000111, 1'b0);
        add(seg_b, 3'b000, 3'b000, DEF, 3'b000, 6'b000000, 1'b0);
        add(seg_b, 3'b111, 3'b000, DEF, 3'b001, 6'b000000, 1'b1);
        add(seg_b, 3'b111, 3'b000, DEF, 3'b001, P0, 1'b1);

        // Reset held across edges with every request asserted.
        req = 3'b111;
        pattern = DEF;
        blink = 3'b111;
        #1;
        expect_now(900, 3'b000, 6'b000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            expect_now(901 + i, 3'b000, 6'b000000, 1'b0);
        end
        @(negedge clk);
        req = 3'b000;
        blink = 3'b000;
        reset_n = 1'b1;

        run_seg(seg_a, 0);

        // Partial-cycle reset pulse while owner 1 is blinking in its off phase.
        #2;
        reset_n = 1'b0;
        req = 3'b000;
        #1;
        expect_now(950, 3'b000, 6'b000000, 1'b0);
        reset_n = 1'b1;

        run_seg(seg_b, 100);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_arbiter.md
Name: led_arbiter

Overview:
- Shares the 6-bit status LED bank between NUM_REQ requesters, e.g. the idle scanner, error-code display and activity indicator.
- Fixed priority: index 0 is highest. A minimum-hold timer prevents flicker from rapid preemption.
- Supports per-requester blink gating.
- Sits between the status sources and the board LED pins. It is the only driver of led.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- HOLD_CYCLES, 5_000_000, minimum clk cycles an owner keeps the LEDs before a higher-priority requester may preempt it.
- BLINK_CYCLES, 2_500_000, clk cycles per blink half-period (on or off).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request per source; level-sensitive, held while the source wants the LEDs.
- pattern  input  6*NUM_REQ  LED pattern per source; source i uses bits [6i+5:6i].
- blink  input  NUM_REQ  1 = blink that source's pattern while it is owner.
- grant  output  NUM_REQ  one-hot current owner, or all-zero when idle; registered.
- led  output  6  LED drive; registered.
- busy  output  1  1 when any grant is active; registered.

Behaviour:
- Reset (reset_n low, asynchronous): grant=0, led=6'b000000, busy=0, state IDLE, hold_cnt=0, blink_cnt=0, phase=1 (on). All of these are held while reset_n is low. Any ongoing ownership is dropped.
- Counter widths: hold_cnt is wide enough for HOLD_CYCLES; blink_cnt is wide enough for BLINK_CYCLES-1. No counter may overflow.
- State IDLE: grant=0, busy=0.
  - If any req bit is high, at the next edge grant the lowest asserted index and enter OWN.
  - Entering OWN sets hold_cnt=0, blink_cnt=0, phase=1.
- State OWN, owner k:
  - hold_cnt increments each cycle and saturates at HOLD_CYCLES.
  - Release: if req[k] is low, at the next edge grant the lowest asserted index among the others, or return to IDLE if none. A release is honoured regardless of hold_cnt.
  - Preempt: if some req[j] with j<k is high and hold_cnt==HOLD_CYCLES, at the next edge grant the lowest such j. hold_cnt, blink_cnt and phase restart.
  - Preempt while hold_cnt<HOLD_CYCLES: the request is ignored and k keeps ownership. Preemption happens on the first edge where the condition holds.
  - Lower-priority requests (j>k) never preempt.
  - Release and preempt together: release rule applies; the lowest asserted index wins.
- Blink: while the owner's blink bit is high, blink_cnt counts 0..BLINK_CYCLES-1. On wrap it returns to 0 and phase toggles.
  - If blink[k] is low, phase is forced to 1 and blink_cnt is held at 0.
  - If blink[k] rises mid-ownership, counting starts from 0 with phase=1.
- led (1-cycle latency after grant):
  - Each edge: led <= (state OWN and phase) ? pattern[k] : 6'b000000.
  - So led first shows the new owner's pattern one cycle after grant changes, and shows 0 one cycle after return to IDLE.
  - Pattern changes by the owner appear on led one cycle later.
  - Non-owner pattern and blink inputs are ignored.
- grant is always one-hot or zero. busy == |grant.
- X or Z on req is not supported.

Test Plan (run with HOLD_CYCLES=4, BLINK_CYCLES=3, NUM_REQ=3):
1. Reset then single request:
   - Stimulus: assert reset_n=0 mid-run, release; raise req=3'b100, pattern2=6'b011111, blink=0.
   - Required: during reset grant=0 and led=0. Grant becomes 3'b100 one edge after req; led=6'b011111 the following edge; busy=1.
2. Blocked, then allowed preemption:
   - Stimulus: req=3'b100 owner established; raise req[0] with pattern0=6'b101010 one cycle after grant.
   - Required: grant stays 3'b100 until hold_cnt reaches 4. The next edge grant=3'b001; led=6'b101010 one edge later.
3. Release with no waiters:
   - Stimulus: owner 1 drops req[1] at hold_cnt=1.
   - Required: grant=0 and busy=0 on the next edge; led=0 one edge after.
4. Release with waiters:
   - Stimulus: owner 0 drops req with req[1] and req[2] high.
   - Required: grant=3'b010 on the next edge, no IDLE cycle in between.
5. Blink:
   - Stimulus: owner 1 with blink[1]=1, pattern=6'b111111.
   - Required: led alternates 6'b111111 for 3 cycles and 6'b000000 for 3 cycles, starting with on. Clearing blink[1] forces led=6'b111111 from the next edge onward.
6. Reset mid-ownership while blinking:
   - Stimulus: pulse reset_n low for a partial cycle.
   - Required: grant, led and busy go to 0 asynchronously. After release, re-arbitration follows the IDLE rules with phase=1.
